fifo_rx_fct: RTL



---
 rtl/fifo_rx_fct_if.sv | 33 +++
 rtl/fifo_rx_fct.sv | 108 ++++++++++
 2 files changed

// File: rtl/fifo_rx_fct_if.sv
// Receive buffer <-> receiver/host/transmitter signal bundle.
// master drives link state, writes, pops and FCT acks; slave is the buffer.
interface fifo_rx_fct_if #(
    parameter int DWIDTH = 9,
    parameter int AWIDTH = 6
);
    logic              link_run;
    logic              wr_en;
    logic [DWIDTH-1:0] data_in;
    logic              rd_en;
    logic [DWIDTH-1:0] data_out;
    logic              data_valid;
    logic              f_full;
    logic              f_empty;
    logic [AWIDTH:0]   counter;
    logic [AWIDTH-1:0] credit;
    logic              fct_req;
    logic              fct_ack;
    logic              overflow;
    logic              credit_err;

    modport master (
        output link_run, wr_en, data_in, rd_en, fct_ack,
        input  data_out, data_valid, f_full, f_empty, counter, credit,
               fct_req, overflow, credit_err
    );

    modport slave (
        input  link_run, wr_en, data_in, rd_en, fct_ack,
        output data_out, data_valid, f_full, f_empty, counter, credit,
               fct_req, overflow, credit_err
    );
endinterface

// File: rtl/fifo_rx_fct.sv
// SpaceWire receive N-Char FIFO with flow-control credit tracking.
// Holds received characters for the host and asks the transmitter for an
// FCT whenever another 8 characters of buffer space can be promised.
module fifo_rx_fct #(
    parameter int DWIDTH = 9,
    parameter int AWIDTH = 6
) (
    input  logic            clock,
    input  logic            reset,
    fifo_rx_fct_if.slave    bus
);
    localparam int DEPTH = 1 << AWIDTH;
    localparam int GRANT = 8;

    typedef enum logic {IDLE = 1'b0, REQ = 1'b1} fct_state_t;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr, rd_ptr;
    fct_state_t        state, state_nxt;

    logic              wr_acc, rd_acc, ack_take, grant_ok;
    logic [AWIDTH:0]   cnt_nxt;
    logic [AWIDTH:0]   credit_add;
    logic [AWIDTH-1:0] credit_nxt;
    logic [AWIDTH+1:0] occupied;

    // Acceptance: a full FIFO still takes a write when a pop frees the slot
    // in the same cycle; an empty FIFO never reads through a same-cycle write.
    always_comb begin
        wr_acc  = bus.wr_en & (~bus.f_full | bus.rd_en);
        rd_acc  = bus.rd_en & ~bus.f_empty;
        cnt_nxt = bus.counter + (AWIDTH+1)'(wr_acc) - (AWIDTH+1)'(rd_acc);
    end

    // Credit: +8 on an acknowledged FCT, -1 per received char (floor 0),
    // and wiped whenever the link leaves Run.
    always_comb begin
        ack_take   = (state == REQ) & bus.fct_ack & bus.link_run;
        credit_add = {1'b0, bus.credit} + (ack_take ? (AWIDTH+1)'(GRANT) : '0);
        if (bus.wr_en && credit_add != '0)
            credit_add = credit_add - 1'b1;
        credit_nxt = bus.link_run ? credit_add[AWIDTH-1:0] : '0;
    end

    // Another FCT may be promised when 8 free slots remain beyond what is
    // stored plus already promised, and credit stays within 56 afterwards.
    always_comb begin
        occupied = {1'b0, bus.counter} + {2'b00, bus.credit};
        grant_ok = bus.link_run
                 & (occupied <= (AWIDTH+2)'(DEPTH - GRANT))
                 & (bus.credit <= AWIDTH'(DEPTH - 2 * GRANT));
    end

    // FCT state register.
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // FCT next-state: link drop abandons a pending request without credit.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant_ok)                        state_nxt = REQ;
            REQ:  if (!bus.link_run || bus.fct_ack)    state_nxt = IDLE;
            default:                                   state_nxt = IDLE;
        endcase
    end

    // FCT output decode.
    always_comb begin
        bus.fct_req = (state == REQ);
    end

    // Storage array; contents are not reset.
    always_ff @(posedge clock) begin
        if (wr_acc) mem[wr_ptr] <= bus.data_in;
    end

    // Pointers, count, flags, popped word and credit bookkeeping.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            bus.counter    <= '0;
            bus.f_full     <= 1'b0;
            bus.f_empty    <= 1'b1;
            bus.data_out   <= '0;
            bus.data_valid <= 1'b0;
            bus.credit     <= '0;
            bus.overflow   <= 1'b0;
            bus.credit_err <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AWIDTH'(1);
            if (rd_acc) begin
                rd_ptr       <= rd_ptr + AWIDTH'(1);
                bus.data_out <= mem[rd_ptr];
            end
            bus.data_valid <= rd_acc;
            bus.counter    <= cnt_nxt;
            bus.f_full     <= (cnt_nxt == (AWIDTH+1)'(DEPTH));
            bus.f_empty    <= (cnt_nxt == '0);
            bus.credit     <= credit_nxt;
            if (bus.wr_en && !wr_acc)             bus.overflow   <= 1'b1;
            if (bus.wr_en && bus.credit == '0)    bus.credit_err <= 1'b1;
        end
    end
endmodule
